// File: rtl/common_bus_datapath_pkg.sv
// rtl/common_bus_datapath_pkg.sv - shared widths, bus-select codes and ALU opcodes
package common_bus_datapath_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [2:0] {
        BUS_NONE = 3'd0,
        BUS_AR   = 3'd1,
        BUS_PC   = 3'd2,
        BUS_DR   = 3'd3,
        BUS_AC   = 3'd4,
        BUS_IR   = 3'd5,
        BUS_TR   = 3'd6,
        BUS_MEM  = 3'd7
    } bus_sel_e;

    typedef enum logic [2:0] {
        ALU_AND = 3'd0,
        ALU_ADD = 3'd1,
        ALU_LDA = 3'd2,
        ALU_CMA = 3'd3,
        ALU_CIR = 3'd4,
        ALU_CIL = 3'd5
    } alu_op_e;

endpackage

// File: rtl/datapath_register.sv
// rtl/datapath_register.sv - bus-loadable register with clear, load and increment
module datapath_register #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             ld,
    input  logic             inr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    // clr beats ld beats inr; increment wraps naturally at the register width
    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (ld) begin
            value_d = d;
        end else if (inr) begin
            value_d = value_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign q = value_q;

endmodule

// File: rtl/common_bus_datapath.sv
// rtl/common_bus_datapath.sv - common-bus datapath: register file, bus mux, AC/E with ALU
module common_bus_datapath
    import common_bus_datapath_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        s,
    input  logic [2:0]        ar_ctl,
    input  logic [2:0]        pc_ctl,
    input  logic [2:0]        tr_ctl,
    input  logic [1:0]        dr_ctl,
    input  logic [2:0]        ac_ctl,
    input  logic              ir_ld,
    input  logic [2:0]        alu_op,
    input  logic [1:0]        e_ctl,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_wr_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic [DATA_W-1:0] bus,
    output logic [DATA_W-1:0] ir_data,
    output logic [DATA_W-1:0] ac_out,
    output logic [DATA_W-1:0] dr_out,
    output logic              e_out
);

    logic [ADDR_W-1:0] ar_q;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] dr_q;
    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] tr_q;
    logic [DATA_W-1:0] ac_q;
    logic [DATA_W-1:0] ac_d;
    logic              e_q;
    logic              e_d;
    logic [DATA_W-1:0] alu_res;
    logic              alu_e;
    logic              alu_e_valid;

    always_comb begin
        bus = '0;
        case (bus_sel_e'(s))
            BUS_AR:  bus = {{(DATA_W-ADDR_W){1'b0}}, ar_q};
            BUS_PC:  bus = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
            BUS_DR:  bus = dr_q;
            BUS_AC:  bus = ac_q;
            BUS_IR:  bus = ir_q;
            BUS_TR:  bus = tr_q;
            BUS_MEM: bus = mem_rdata;
            default: bus = '0;
        endcase
    end

    datapath_register #(.WIDTH(ADDR_W)) u_ar (
        .clk(clk), .rst_n(rst_n),
        .clr(ar_ctl[2]), .ld(ar_ctl[0]), .inr(ar_ctl[1]),
        .d(bus[ADDR_W-1:0]), .q(ar_q)
    );

    datapath_register #(.WIDTH(ADDR_W)) u_pc (
        .clk(clk), .rst_n(rst_n),
        .clr(pc_ctl[2]), .ld(pc_ctl[0]), .inr(pc_ctl[1]),
        .d(bus[ADDR_W-1:0]), .q(pc_q)
    );

    datapath_register #(.WIDTH(DATA_W)) u_dr (
        .clk(clk), .rst_n(rst_n),
        .clr(1'b0), .ld(dr_ctl[0]), .inr(dr_ctl[1]),
        .d(bus), .q(dr_q)
    );

    datapath_register #(.WIDTH(DATA_W)) u_tr (
        .clk(clk), .rst_n(rst_n),
        .clr(tr_ctl[2]), .ld(tr_ctl[0]), .inr(tr_ctl[1]),
        .d(bus), .q(tr_q)
    );

    datapath_register #(.WIDTH(DATA_W)) u_ir (
        .clk(clk), .rst_n(rst_n),
        .clr(1'b0), .ld(ir_ld), .inr(1'b0),
        .d(bus), .q(ir_q)
    );

    // ALU sees pre-edge AC/DR/E; alu_e_valid marks ops that produce a new E
    always_comb begin
        alu_res     = ac_q;
        alu_e       = e_q;
        alu_e_valid = 1'b0;
        case (alu_op)
            ALU_AND: alu_res = ac_q & dr_q;
            ALU_ADD: begin
                {alu_e, alu_res} = {1'b0, ac_q} + {1'b0, dr_q};
                alu_e_valid      = 1'b1;
            end
            ALU_LDA: alu_res = dr_q;
            ALU_CMA: alu_res = ~ac_q;
            ALU_CIR: begin
                alu_res     = {e_q, ac_q[DATA_W-1:1]};
                alu_e       = ac_q[0];
                alu_e_valid = 1'b1;
            end
            ALU_CIL: begin
                alu_res     = {ac_q[DATA_W-2:0], e_q};
                alu_e       = ac_q[DATA_W-1];
                alu_e_valid = 1'b1;
            end
            default: alu_res = ac_q;
        endcase
    end

    always_comb begin
        ac_d = ac_q;
        if (ac_ctl[2]) begin
            ac_d = '0;
        end else if (ac_ctl[0]) begin
            ac_d = alu_res;
        end else if (ac_ctl[1]) begin
            ac_d = ac_q + DATA_W'(1);
        end
    end

    // ALU-produced E only lands when AC actually takes the ALU result
    always_comb begin
        e_d = e_q;
        if (e_ctl[1]) begin
            e_d = 1'b0;
        end else if (e_ctl[0]) begin
            e_d = ~e_q;
        end else if (ac_ctl[0] && !ac_ctl[2] && alu_e_valid) begin
            e_d = alu_e;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ac_q <= '0;
            e_q  <= 1'b0;
        end else begin
            ac_q <= ac_d;
            e_q  <= e_d;
        end
    end

    assign mem_addr  = ar_q;
    assign mem_wdata = bus;
    assign mem_we    = mem_wr_in;
    assign ir_data   = ir_q;
    assign ac_out    = ac_q;
    assign dr_out    = dr_q;
    assign e_out     = e_q;

endmodule

// File: tb/tb_common_bus_datapath.sv
// tb/tb_common_bus_datapath.sv - randomized and directed checks against a behavioural model
module tb_common_bus_datapath;

    localparam int AW = 12;
    localparam int DW = 16;

    logic          clk;
    logic          rst_n;
    logic [2:0]    s;
    logic [2:0]    ar_ctl, pc_ctl, tr_ctl, ac_ctl, alu_op;
    logic [1:0]    dr_ctl, e_ctl;
    logic          ir_ld;
    logic [DW-1:0] mem_rdata;
    logic          mem_wr_in;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, bus, ir_data, ac_out, dr_out;
    logic          mem_we, e_out;

    common_bus_datapath #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .s(s),
        .ar_ctl(ar_ctl), .pc_ctl(pc_ctl), .tr_ctl(tr_ctl), .dr_ctl(dr_ctl),
        .ac_ctl(ac_ctl), .ir_ld(ir_ld), .alu_op(alu_op), .e_ctl(e_ctl),
        .mem_rdata(mem_rdata), .mem_wr_in(mem_wr_in),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .bus(bus), .ir_data(ir_data), .ac_out(ac_out), .dr_out(dr_out), .e_out(e_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    int m_ar, m_pc, m_dr, m_ac, m_ir, m_tr, m_e;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ar = 0; m_pc = 0; m_dr = 0; m_ac = 0; m_ir = 0; m_tr = 0; m_e = 0;
    endtask

    function automatic int model_bus();
        case (s)
            3'd1:    return m_ar;
            3'd2:    return m_pc;
            3'd3:    return m_dr;
            3'd4:    return m_ac;
            3'd5:    return m_ir;
            3'd6:    return m_tr;
            3'd7:    return int'(mem_rdata);
            default: return 0;
        endcase
    endfunction

    function automatic int upd(input int cur, input bit clr, input bit ld, input bit inr,
                               input int ldv, input int modulus);
        if (clr) return 0;
        if (ld)  return ldv % modulus;
        if (inr) return (cur + 1) % modulus;
        return cur;
    endfunction

    task automatic model_step();
        int b, nac, ne, alu_ac, alu_e, x, y;
        bit e_from_alu;
        if (!rst_n) begin
            model_reset();
            return;
        end
        b = model_bus();
        e_from_alu = 1'b0;
        alu_ac = m_ac;
        alu_e  = m_e;
        case (alu_op)
            3'd0: alu_ac = m_ac & m_dr;
            3'd1: begin
                x = m_ac + m_dr;
                alu_ac = x % 65536; alu_e = x / 65536; e_from_alu = 1'b1;
            end
            3'd2: alu_ac = m_dr;
            3'd3: alu_ac = 65535 - m_ac;
            3'd4: begin
                x = m_e * 65536 + m_ac;
                y = (x / 2) + (x % 2) * 65536;
                alu_ac = y % 65536; alu_e = y / 65536; e_from_alu = 1'b1;
            end
            3'd5: begin
                x = m_e * 65536 + m_ac;
                y = (x * 2) % 131072 + x / 65536;
                alu_ac = y % 65536; alu_e = y / 65536; e_from_alu = 1'b1;
            end
            default: alu_ac = m_ac;
        endcase
        if (ac_ctl[2])      nac = 0;
        else if (ac_ctl[0]) nac = alu_ac;
        else if (ac_ctl[1]) nac = (m_ac + 1) % 65536;
        else                nac = m_ac;
        if (e_ctl[1])                               ne = 0;
        else if (e_ctl[0])                          ne = 1 - m_e;
        else if (ac_ctl[0] && !ac_ctl[2] && e_from_alu) ne = alu_e;
        else                                        ne = m_e;
        m_ar = upd(m_ar, ar_ctl[2], ar_ctl[0], ar_ctl[1], b, 4096);
        m_pc = upd(m_pc, pc_ctl[2], pc_ctl[0], pc_ctl[1], b, 4096);
        m_tr = upd(m_tr, tr_ctl[2], tr_ctl[0], tr_ctl[1], b, 65536);
        m_dr = upd(m_dr, 1'b0, dr_ctl[0], dr_ctl[1], b, 65536);
        m_ir = upd(m_ir, 1'b0, ir_ld, 1'b0, b, 65536);
        m_ac = nac;
        m_e  = ne;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("bus",       int'(bus),       model_bus());
            chk("mem_wdata", int'(mem_wdata), model_bus());
            chk("mem_addr",  int'(mem_addr),  m_ar);
            chk("mem_we",    int'(mem_we),    int'(mem_wr_in));
            chk("ir_data",   int'(ir_data),   m_ir);
            chk("ac_out",    int'(ac_out),    m_ac);
            chk("dr_out",    int'(dr_out),    m_dr);
            chk("e_out",     int'(e_out),     m_e);
        end
    end

    task automatic idle();
        s = 3'd0; ar_ctl = '0; pc_ctl = '0; tr_ctl = '0; dr_ctl = '0; ac_ctl = '0;
        ir_ld = 1'b0; alu_op = '0; e_ctl = '0; mem_wr_in = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #2;
        idle();
    endtask

    task automatic peek_bus(input logic [2:0] sel, input string name, input int exp);
        s = sel;
        #1;
        chk(name, int'(bus), exp);
    endtask

    task automatic from_mem(input int v);
        s = 3'd7;
        mem_rdata = DW'(v);
    endtask

    function automatic bit rb(input int n);
        return $urandom_range(n - 1) == 0;
    endfunction

    initial begin
        idle();
        mem_rdata = '0;
        rst_n = 1'b0;
        model_reset();
        #3;
        chk("rst_bus",  int'(bus),      0);
        chk("rst_ac",   int'(ac_out),   0);
        chk("rst_addr", int'(mem_addr), 0);
        #9;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // PC=0x123 then asynchronous reset mid-cycle
        from_mem(32'h123); pc_ctl = 3'b001; cycle();
        peek_bus(3'd2, "pc_pre_reset", 32'h123);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_pc", int'(bus), 0);
        s = 3'd0;
        cycle();
        rst_n = 1'b1;

        // fetch
        from_mem(32'h010); pc_ctl = 3'b001; cycle();
        s = 3'd2; ar_ctl = 3'b001; cycle();
        #1 chk("fetch_ar", int'(mem_addr), 32'h010);
        from_mem(32'h7800); ir_ld = 1'b1; pc_ctl = 3'b010; cycle();
        #1 chk("fetch_ir", int'(ir_data), 32'h7800);
        peek_bus(3'd2, "fetch_pc", 32'h011);

        // wrap and priority
        from_mem(32'hFFF); pc_ctl = 3'b001; cycle();
        pc_ctl = 3'b010; cycle();
        peek_bus(3'd2, "pc_wrap", 0);
        from_mem(32'h555); pc_ctl = 3'b001; cycle();
        from_mem(32'hAAA); pc_ctl = 3'b111; cycle();
        peek_bus(3'd2, "pc_clr_prio", 0);

        // ADD carry then complement E
        from_mem(32'hFFFF); dr_ctl = 2'b01; cycle();
        alu_op = 3'd2; ac_ctl = 3'b001; cycle();
        from_mem(32'h0001); dr_ctl = 2'b01; e_ctl = 2'b10; cycle();
        alu_op = 3'd1; ac_ctl = 3'b001; cycle();
        #1 chk("add_ac", int'(ac_out), 0);
        chk("add_e", int'(e_out), 1);
        e_ctl = 2'b01; cycle();
        #1 chk("cmp_e", int'(e_out), 0);

        // rotates
        from_mem(32'h8001); dr_ctl = 2'b01; e_ctl = 2'b10; cycle();
        alu_op = 3'd2; ac_ctl = 3'b001; cycle();
        alu_op = 3'd5; ac_ctl = 3'b001; cycle();
        #1 chk("cil_ac", int'(ac_out), 32'h0002);
        chk("cil_e", int'(e_out), 1);
        alu_op = 3'd4; ac_ctl = 3'b001; cycle();
        #1 chk("cir_ac", int'(ac_out), 32'h8001);
        chk("cir_e", int'(e_out), 0);

        // AC to TR through the bus, then write TR out to memory
        from_mem(32'h1234); dr_ctl = 2'b01; cycle();
        alu_op = 3'd2; ac_ctl = 3'b001; from_mem(32'h5678); tr_ctl = 3'b001; cycle();
        peek_bus(3'd6, "tr_pre", 32'h5678);
        s = 3'd4; tr_ctl = 3'b001; cycle();
        s = 3'd6; mem_wr_in = 1'b1;
        #1;
        chk("wr_we",    int'(mem_we),    1);
        chk("wr_wdata", int'(mem_wdata), 32'h1234);
        chk("wr_addr",  int'(mem_addr),  32'h010);
        cycle();

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            s         = 3'($urandom_range(7));
            ar_ctl    = {rb(10), rb(4), rb(4)};
            pc_ctl    = {rb(10), rb(3), rb(4)};
            tr_ctl    = {rb(10), rb(4), rb(4)};
            dr_ctl    = {rb(4), rb(3)};
            ac_ctl    = {rb(10), rb(4), rb(2)};
            ir_ld     = rb(4);
            alu_op    = 3'($urandom_range(7));
            e_ctl     = {rb(10), rb(6)};
            mem_rdata = DW'($urandom);
            mem_wr_in = rb(2);
            if (rb(100)) begin
                rst_n = 1'b0;
                model_reset();
            end else begin
                rst_n = 1'b1;
            end
            #1;
            chk("rnd_bus", int'(bus), model_bus());
            @(posedge clk);
            model_step();
            #2;
        end
        rst_n = 1'b1;
        idle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
